sim_run_ctrl: RTL and testbench
===============================

# sim_run_ctrl

Parametrised run controller for simulation and FPGA bring-up, sitting between the top-level clock/reset pins and `riscv_top`. It stretches the external reset into a CPU reset of programmable length and counts execution cycles. It ends the run on a halt request from any of N sources, or on a cycle-budget timeout. An optional drain window lets the UART flush before `finish` pulses. It generalises the fixed 25-cycle reset and fixed-time stop of the old bench into a reusable, synthesizable block with halt detection.

## Interface
Parameters:
- RST_CYCLES, 25, number of clk edges `cpu_rst` stays high after `rst` falls (≥1)
- TIMEOUT_CYCLES, 150000, RUN-cycle budget; 0 disables timeout
- DRAIN_CYCLES, 0, cycles spent in DRAIN after a halt before DONE
- N_HALT, 1, number of halt-request inputs (≥1)
- CNT_WIDTH, 32, width of `cycle_cnt` (must hold TIMEOUT_CYCLES)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- halt_req  in  N_HALT  per-source halt request, level, sampled only in RUN
- cpu_rst  out  1  reset to `riscv_top`
- running  out  1  high in RUN
- done  out  1  sticky, run ended by halt
- timeout  out  1  sticky, run ended by budget
- finish  out  1  one-cycle pulse on entry to DONE or TIMEOUT
- halt_src  out  max(1,$clog2(N_HALT))  index of winning halt source
- cycle_cnt  out  CNT_WIDTH  RUN cycles elapsed

## Operation
- States: RESET, RUN, DRAIN, DONE, TIMEOUT.
- `rst`=1 at an edge forces the following reset values:
  - state RESET
  - `cpu_rst`=1
  - `running`=0, `done`=0, `timeout`=0, `finish`=0
  - `halt_src`=0, `cycle_cnt`=0
  - internal reset/drain counters = 0
  - Applies from any state, including mid-run and mid-drain.
- RESET: the reset counter increments each edge with `rst`=0. When the counter reaches RST_CYCLES-1, the state goes to RUN and `cpu_rst` drops on that edge.
- RUN:
  - `cycle_cnt` increments by 1 every edge and saturates at all-ones.
  - If any `halt_req` bit is set, latch `halt_src` = lowest set index and go to DRAIN.
  - Otherwise, if TIMEOUT_CYCLES≠0 and `cycle_cnt`==TIMEOUT_CYCLES-1, go to TIMEOUT.
  - When halt and timeout occur on the same edge, halt wins.
- DRAIN:
  - `cycle_cnt` is frozen and `cpu_rst` stays 0.
  - The drain counter runs to DRAIN_CYCLES, then the state goes to DONE.
  - If DRAIN_CYCLES=0, RUN goes directly to DONE on the halt edge.
- DONE / TIMEOUT:
  - Terminal; exit only via `rst`.
  - `finish`=1 for exactly the first cycle in the state.
  - `done` or `timeout` is held high.
  - `cycle_cnt` and `halt_src` are frozen.
- `halt_req` is ignored outside RUN. Requests asserted during RESET must not end the run early.

## Timing
- All outputs are registered; no combinational path from `halt_req` or `rst` to any output.
- `rst` falls before edge k (k = first edge with `rst`=0): `cpu_rst` is high through edge k+RST_CYCLES-1 and low after it.
- `cycle_cnt` reads 1 after the first RUN edge.
- Halt sampled at edge h: `running`=0 after h.
  - DRAIN_CYCLES=0: `done` and `finish` are high after h.
  - Otherwise: `done` and `finish` are high after edge h+DRAIN_CYCLES.
- Timeout: `timeout` and `finish` are high after the edge where `cycle_cnt` becomes TIMEOUT_CYCLES. `cycle_cnt` then reads TIMEOUT_CYCLES.
- `rst` high for a single edge is a full reset; the reset sequence restarts from count 0.

## Structure
- Package `sim_ctrl_pkg` holds:
  - state encoding (5 states, 3-bit localparams)
  - shared constant `HALT_W` = max(1,$clog2(N_HALT)) helper function
- Sub-module `prio_enc` (N_HALT → index + valid), lowest index wins. Reused by other arbitration blocks.
- Everything else (counters, FSM) is inline in `sim_run_ctrl`.
- Top-level bench instantiates this block, feeds `clk`, and drives `riscv_top` reset from `cpu_rst`. It calls `$finish` on `finish`.

## Test plan
- RST_CYCLES=25, `rst` high 3 cycles then low → `cpu_rst` high for exactly 25 edges after release; `running` rises on the same edge `cpu_rst` falls.
- TIMEOUT_CYCLES=100, no halt → `timeout`=1, `finish` pulses once, `cycle_cnt`=100, `done`=0; all hold for 50 further cycles.
- N_HALT=4, `halt_req`=4'b1010 at RUN cycle 37, DRAIN_CYCLES=0 → `halt_src`=1, `done`=1, `cycle_cnt`=37 frozen.
- TIMEOUT_CYCLES=50, `halt_req` first set on the edge where `cycle_cnt` becomes 50 → `done`=1, `timeout`=0 (halt wins).
- DRAIN_CYCLES=8, halt at cycle 20 → `running`=0 next cycle, `finish` exactly 8 cycles later, `cycle_cnt`=20 throughout.
- `rst` asserted mid-DRAIN, and `halt_req` held high during RESET → full reset values; no early exit; a fresh 25-cycle `cpu_rst` precedes a RUN whose first edge halts.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared state encoding and width helpers for the simulation run controller
// and its arbitration sub-blocks.
package sim_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_RESET   = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_DRAIN   = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_TIMEOUT = 3'd4;

    // Index width for n requesters; a single requester still gets one bit.
    function automatic int halt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sim_run_ctrl_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index plus a valid
// flag. Purely combinational.
module prio_enc
    import sim_ctrl_pkg::*;
#(
    parameter int N = 1,
    parameter int W = halt_width(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: stretches the board reset into a CPU reset, counts RUN
// cycles and ends the run on a halt request or when the cycle budget is used.
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int RST_CYCLES     = 25,
    parameter int TIMEOUT_CYCLES = 150000,
    parameter int DRAIN_CYCLES   = 0,
    parameter int N_HALT         = 1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_HALT-1:0]               halt_req,
    output logic                            cpu_rst,
    output logic                            running,
    output logic                            done,
    output logic                            timeout,
    output logic                            finish,
    output logic [halt_width(N_HALT)-1:0]   halt_src,
    output logic [CNT_WIDTH-1:0]            cycle_cnt
);

    localparam int HALT_W = halt_width(N_HALT);
    localparam int RST_W  = cnt_width(RST_CYCLES);
    localparam int DRN_W  = cnt_width(DRAIN_CYCLES);

    localparam logic [RST_W-1:0] RST_LAST =
        RST_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
    localparam logic [DRN_W-1:0] DRN_LAST =
        DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] TO_LAST =
        CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam bit DRAIN_EN   = (DRAIN_CYCLES != 0);

    state_t            state;
    logic [RST_W-1:0]  rst_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic [HALT_W-1:0] halt_idx;
    logic              halt_vld;

    prio_enc #(
        .N (N_HALT),
        .W (HALT_W)
    ) u_prio_enc (
        .req (halt_req),
        .idx (halt_idx),
        .vld (halt_vld)
    );

    // Every output is a flop; halt_req only reaches them through the RUN branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RESET;
            cpu_rst   <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            finish    <= 1'b0;
            halt_src  <= '0;
            cycle_cnt <= '0;
            rst_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            finish <= 1'b0;
            case (state)
                ST_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= ST_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    // A halt on the budget edge still counts as a clean halt.
                    if (halt_vld) begin
                        halt_src <= halt_idx;
                        running  <= 1'b0;
                        if (DRAIN_EN) begin
                            state <= ST_DRAIN;
                        end else begin
                            state  <= ST_DONE;
                            done   <= 1'b1;
                            finish <= 1'b1;
                        end
                    end else if (TIMEOUT_EN && (cycle_cnt == TO_LAST)) begin
                        state   <= ST_TIMEOUT;
                        running <= 1'b0;
                        timeout <= 1'b1;
                        finish  <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (drain_cnt == DRN_LAST) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        finish <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                ST_DONE, ST_TIMEOUT: begin
                end

                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Scoreboard bench for sim_run_ctrl: two configurations share one clock; the
// expected end-of-run record is queued at stimulus time and checked on finish.
module tb_sim_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        done;
        logic        timeout;
        logic [31:0] src;
        logic [31:0] cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Configuration A: no drain, 4 halt sources, 100-cycle budget.
    logic        a_rst = 1'b1;
    logic [3:0]  a_halt = 4'b0;
    logic        a_cpu_rst, a_running, a_done, a_timeout, a_finish;
    logic [1:0]  a_src;
    logic [31:0] a_cnt;

    // Configuration B: 8-cycle drain, 2 halt sources, 50-cycle budget.
    logic        b_rst = 1'b1;
    logic [1:0]  b_halt = 2'b0;
    logic        b_cpu_rst, b_running, b_done, b_timeout, b_finish;
    logic [0:0]  b_src;
    logic [15:0] b_cnt;

    sim_run_ctrl #(
        .RST_CYCLES(25), .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(0),
        .N_HALT(4), .CNT_WIDTH(32)
    ) u_a (
        .clk(clk), .rst(a_rst), .halt_req(a_halt), .cpu_rst(a_cpu_rst),
        .running(a_running), .done(a_done), .timeout(a_timeout),
        .finish(a_finish), .halt_src(a_src), .cycle_cnt(a_cnt)
    );

    sim_run_ctrl #(
        .RST_CYCLES(25), .TIMEOUT_CYCLES(50), .DRAIN_CYCLES(8),
        .N_HALT(2), .CNT_WIDTH(16)
    ) u_b (
        .clk(clk), .rst(b_rst), .halt_req(b_halt), .cpu_rst(b_cpu_rst),
        .running(b_running), .done(b_done), .timeout(b_timeout),
        .finish(b_finish), .halt_src(b_src), .cycle_cnt(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: each finish pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (a_finish) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_finish", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                chk("a_sb_done", 32'(a_done), 32'(e.done));
                chk("a_sb_timeout", 32'(a_timeout), 32'(e.timeout));
                chk("a_sb_src", 32'(a_src), e.src);
                chk("a_sb_cnt", a_cnt, e.cnt);
            end
        end
        if (b_finish) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_finish", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                chk("b_sb_done", 32'(b_done), 32'(e.done));
                chk("b_sb_timeout", 32'(b_timeout), 32'(e.timeout));
                chk("b_sb_src", 32'(b_src), e.src);
                chk("b_sb_cnt", 32'(b_cnt), e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk_a_reset(input string tag);
        chk({tag, "_cpu_rst"}, 32'(a_cpu_rst), 32'd1);
        chk({tag, "_running"}, 32'(a_running), 32'd0);
        chk({tag, "_done"}, 32'(a_done), 32'd0);
        chk({tag, "_timeout"}, 32'(a_timeout), 32'd0);
        chk({tag, "_finish"}, 32'(a_finish), 32'd0);
        chk({tag, "_src"}, 32'(a_src), 32'd0);
        chk({tag, "_cnt"}, a_cnt, 32'd0);
    endtask

    task automatic chk_b_reset(input string tag);
        chk({tag, "_cpu_rst"}, 32'(b_cpu_rst), 32'd1);
        chk({tag, "_running"}, 32'(b_running), 32'd0);
        chk({tag, "_done"}, 32'(b_done), 32'd0);
        chk({tag, "_timeout"}, 32'(b_timeout), 32'd0);
        chk({tag, "_finish"}, 32'(b_finish), 32'd0);
        chk({tag, "_src"}, 32'(b_src), 32'd0);
        chk({tag, "_cnt"}, 32'(b_cnt), 32'd0);
    endtask

    initial begin
        int n;

        // A: reset held 3 edges, then measure cpu_rst stretch.
        tick(3);
        chk_a_reset("a_rst0");
        a_rst = 1'b0;
        n = 0;
        while (a_cpu_rst && n < 100) begin
            tick(1);
            n++;
        end
        chk("a_rst_len", 32'(n), 32'd25);
        chk("a_run_rise", 32'(a_running), 32'd1);
        chk("a_run_cnt0", a_cnt, 32'd0);

        // A: budget run, no halt.
        qa.push_back('{done: 1'b0, timeout: 1'b1, src: 32'd0, cnt: 32'd100});
        tick(1);
        chk("a_cnt_first", a_cnt, 32'd1);
        tick(98);
        chk("a_cnt_99", a_cnt, 32'd99);
        chk("a_to_early", 32'(a_timeout), 32'd0);
        tick(1);
        chk("a_to_set", 32'(a_timeout), 32'd1);
        chk("a_to_running", 32'(a_running), 32'd0);
        chk("a_to_cnt", a_cnt, 32'd100);
        a_halt = 4'b1111;
        tick(50);
        chk("a_to_hold", 32'(a_timeout), 32'd1);
        chk("a_to_done", 32'(a_done), 32'd0);
        chk("a_to_cnt_hold", a_cnt, 32'd100);
        chk("a_to_src_hold", 32'(a_src), 32'd0);
        chk("a_to_finish_low", 32'(a_finish), 32'd0);

        // A: single-edge reset, then halt 4'b1010 on the 37th RUN edge.
        a_halt = 4'b0;
        a_rst = 1'b1;
        tick(1);
        chk_a_reset("a_rst1");
        a_rst = 1'b0;
        tick(24);
        chk("a_rst1_still", 32'(a_cpu_rst), 32'd1);
        tick(1);
        chk("a_rst1_run", 32'(a_running), 32'd1);
        tick(36);
        chk("a_cnt_36", a_cnt, 32'd36);
        a_halt = 4'b1010;
        qa.push_back('{done: 1'b1, timeout: 1'b0, src: 32'd1, cnt: 32'd37});
        tick(1);
        chk("a_halt_running", 32'(a_running), 32'd0);
        chk("a_halt_done", 32'(a_done), 32'd1);
        chk("a_halt_src", 32'(a_src), 32'd1);
        a_halt = 4'b0001;
        tick(10);
        chk("a_halt_cnt_frozen", a_cnt, 32'd37);
        chk("a_halt_src_frozen", 32'(a_src), 32'd1);
        chk("a_halt_cpu_rst", 32'(a_cpu_rst), 32'd0);

        // B: halt arrives on the same edge the budget expires; halt wins.
        tick(1);
        chk_b_reset("b_rst0");
        b_rst = 1'b0;
        tick(25);
        chk("b_run", 32'(b_running), 32'd1);
        tick(49);
        chk("b_cnt_49", 32'(b_cnt), 32'd49);
        b_halt = 2'b01;
        qb.push_back('{done: 1'b1, timeout: 1'b0, src: 32'd0, cnt: 32'd50});
        tick(1);
        b_halt = 2'b00;
        chk("b_tie_timeout", 32'(b_timeout), 32'd0);
        chk("b_tie_running", 32'(b_running), 32'd0);
        chk("b_tie_cnt", 32'(b_cnt), 32'd50);
        tick(7);
        chk("b_tie_drain_done", 32'(b_done), 32'd0);
        tick(1);
        chk("b_tie_done", 32'(b_done), 32'd1);
        chk("b_tie_timeout2", 32'(b_timeout), 32'd0);

        // B: 8-cycle drain after a halt on RUN edge 20, source 1.
        b_rst = 1'b1;
        tick(1);
        b_rst = 1'b0;
        tick(25);
        tick(19);
        chk("b_cnt_19", 32'(b_cnt), 32'd19);
        b_halt = 2'b10;
        qb.push_back('{done: 1'b1, timeout: 1'b0, src: 32'd1, cnt: 32'd20});
        tick(1);
        b_halt = 2'b00;
        chk("b_drn_running", 32'(b_running), 32'd0);
        chk("b_drn_cnt", 32'(b_cnt), 32'd20);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            chk("b_drn_finish_low", 32'(b_finish), 32'd0);
            chk("b_drn_cnt_frozen", 32'(b_cnt), 32'd20);
            chk("b_drn_cpu_rst", 32'(b_cpu_rst), 32'd0);
        end
        tick(1);
        chk("b_drn_finish", 32'(b_finish), 32'd1);
        chk("b_drn_done", 32'(b_done), 32'd1);
        chk("b_drn_src", 32'(b_src), 32'd1);

        // B: reset mid-drain while halt_req is held through RESET.
        b_rst = 1'b1;
        tick(1);
        b_rst = 1'b0;
        tick(25);
        tick(4);
        b_halt = 2'b01;
        tick(4);
        b_halt = 2'b11;
        b_rst = 1'b1;
        tick(2);
        chk_b_reset("b_rst_mid");
        b_rst = 1'b0;
        n = 0;
        while (b_cpu_rst && n < 100) begin
            tick(1);
            n++;
            if (b_cpu_rst) chk("b_rst_no_exit", 32'(b_done | b_running), 32'd0);
        end
        chk("b_rst_len", 32'(n), 32'd25);
        qb.push_back('{done: 1'b1, timeout: 1'b0, src: 32'd0, cnt: 32'd1});
        tick(1);
        chk("b_first_halt_running", 32'(b_running), 32'd0);
        chk("b_first_halt_cnt", 32'(b_cnt), 32'd1);
        tick(8);
        chk("b_first_halt_done", 32'(b_done), 32'd1);
        b_halt = 2'b00;

        tick(3);
        chk("a_sb_pending", 32'(qa.size()), 32'd0);
        chk("b_sb_pending", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
